bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 130 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the segment decoders.
package bcd_pkg;

    // Sign glyph codes understood by the seven-segment digit decoders.
    localparam logic [3:0] SGN_MINUS = 4'hA;
    localparam logic [3:0] SGN_BLANK = 4'hF;

    // Converter control states.
    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: any digit of 5 or more gets +3 ahead of the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative signed binary to sign-magnitude BCD converter (shift-and-add-3).
// One bit per clock; results, sign glyph and overflow update together with done.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic [3:0]          bcd_sgn,
    output logic                ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_e           state_q, state_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [3:0]       sgn_q, sgn_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] bin_abs;
    logic [BCD_W-1:0] corrected;
    logic [BCD_W-1:0] scratch_shifted;
    logic             carry_out;
    logic             carry_any;

    // Most negative input maps to 2^(WIDTH-1), which still fits as unsigned.
    assign bin_abs = bin[WIDTH-1] ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_add3 u_add3 (
            .digit    (scratch_q[4*d +: 4]),
            .adjusted (corrected[4*d +: 4])
        );
    end

    // A bit leaving the top digit means the magnitude no longer fits in DIGITS.
    assign scratch_shifted = {corrected[BCD_W-2:0], mag_q[WIDTH-1]};
    assign carry_out       = corrected[BCD_W-1];
    assign carry_any       = carry_q | carry_out;

    // Next-state logic: capture on accepted start, iterate, publish on last step.
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        sgn_d     = sgn_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    neg_d     = bin[WIDTH-1] && (bin_abs != '0);
                    mag_d     = bin_abs;
                    scratch_d = '0;
                    cnt_d     = CNT_LOAD;
                    carry_d   = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = scratch_shifted;
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                carry_d   = carry_any;
                cnt_d     = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ovf_d   = carry_any;
                    bcd_d   = carry_any ? '1 : scratch_shifted;
                    sgn_d   = neg_q ? SGN_MINUS : SGN_BLANK;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            scratch_q <= '0;
            mag_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            sgn_q     <= SGN_BLANK;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            sgn_q     <= sgn_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == StShift);
    assign done    = done_q;
    assign bcd     = bcd_q;
    assign bcd_sgn = sgn_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 12-bit and a 16-bit instance checked every cycle
// against an arithmetic model, plus directed vectors with literal results.
module tb_bin2bcd_seq;

    localparam int WA = 12;
    localparam int WB = 16;

    typedef struct packed {
        logic        ovf;
        logic [3:0]  sgn;
        logic [15:0] bcd;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [WA-1:0] bin_a = '0;
    logic [WB-1:0] bin_b = '0;
    logic          busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0]   bcd_a, bcd_b;
    logic [3:0]    sgn_a, sgn_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(WA), .DIGITS(4)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_a),
        .bin     (bin_a),
        .busy    (busy_a),
        .done    (done_a),
        .bcd     (bcd_a),
        .bcd_sgn (sgn_a),
        .ovf     (ovf_a)
    );

    bin2bcd_seq #(.WIDTH(WB), .DIGITS(4)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_b),
        .bin     (bin_b),
        .busy    (busy_b),
        .done    (done_b),
        .bcd     (bcd_b),
        .bcd_sgn (sgn_b),
        .ovf     (ovf_b)
    );

    // Decimal conversion by plain division.
    function automatic res_t convert(input int value);
        res_t        r;
        int unsigned mag;
        int unsigned rest;
        mag   = (value < 0) ? $unsigned(-value) : $unsigned(value);
        r.sgn = (value < 0) ? 4'hA : 4'hF;
        r.ovf = (mag >= 10000);
        rest  = mag;
        for (int i = 0; i < 4; i++) begin
            r.bcd[4*i +: 4] = 4'(rest % 10);
            rest = rest / 10;
        end
        if (r.ovf) r.bcd = 16'hFFFF;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: a conversion takes WIDTH cycles, then one done cycle in idle.
    int unsigned a_left, b_left;
    logic        a_done, b_done;
    res_t        a_pend, a_res, b_pend, b_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_left <= 0;
            a_done <= 1'b0;
            a_res  <= {1'b0, 4'hF, 16'h0000};
        end else begin
            a_done <= 1'b0;
            if (a_left == 0) begin
                if (start_a) begin
                    a_left <= WA;
                    a_pend <= convert(int'($signed(bin_a)));
                end
            end else begin
                a_left <= a_left - 1;
                if (a_left == 1) begin
                    a_done <= 1'b1;
                    a_res  <= a_pend;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_left <= 0;
            b_done <= 1'b0;
            b_res  <= {1'b0, 4'hF, 16'h0000};
        end else begin
            b_done <= 1'b0;
            if (b_left == 0) begin
                if (start_b) begin
                    b_left <= WB;
                    b_pend <= convert(int'($signed(bin_b)));
                end
            end else begin
                b_left <= b_left - 1;
                if (b_left == 1) begin
                    b_done <= 1'b1;
                    b_res  <= b_pend;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cycle_a", {busy_a, done_a, ovf_a, sgn_a, bcd_a},
                      {a_left != 0, a_done, a_res.ovf, a_res.sgn, a_res.bcd});
                check("cycle_b", {busy_b, done_b, ovf_b, sgn_b, bcd_b},
                      {b_left != 0, b_done, b_res.ovf, b_res.sgn, b_res.bcd});
            end
        end
    end

    // One conversion on channel ch (0: 12-bit, 1: 16-bit) with literal results.
    task automatic run(input int ch, input logic [15:0] value, input logic [15:0] exp_bcd,
                       input logic [3:0] exp_sgn, input logic exp_ovf, input string name);
        int   n;
        logic seen;
        res_t m;
        @(negedge clk);
        if (ch == 0) begin
            start_a = 1'b1;
            bin_a   = value[WA-1:0];
        end else begin
            start_b = 1'b1;
            bin_b   = value;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            start_a = 1'b0;
            start_b = 1'b0;
            seen    = (ch == 0) ? done_a : done_b;
        end
        check({name, " latency"}, n - 1, (ch == 0) ? WA : WB);
        if (ch == 0) begin
            check({name, " result"}, {ovf_a, sgn_a, bcd_a}, {exp_ovf, exp_sgn, exp_bcd});
            m = a_res;
        end else begin
            check({name, " result"}, {ovf_b, sgn_b, bcd_b}, {exp_ovf, exp_sgn, exp_bcd});
            m = b_res;
        end
        check({name, " model"}, m, {exp_ovf, exp_sgn, exp_bcd});
    endtask

    initial begin
        int n, first, second, dones;

        repeat (2) @(negedge clk);
        check("reset busy_a", busy_a, 0);
        check("reset done_a", done_a, 0);
        check("reset out_a", {ovf_a, sgn_a, bcd_a}, {1'b0, 4'hF, 16'h0000});
        check("reset out_b", {busy_b, ovf_b, sgn_b, bcd_b}, {1'b0, 1'b0, 4'hF, 16'h0000});
        rst_n = 1'b1;

        run(0, 16'h0000, 16'h0000, 4'hF, 1'b0, "zero");
        run(0, 16'd2047, 16'h2047, 4'hF, 1'b0, "max_pos");
        run(0, 16'h0FFF, 16'h0001, 4'hA, 1'b0, "minus_one");
        run(0, 16'h0800, 16'h2048, 4'hA, 1'b0, "min_neg");
        run(0, 16'h0C19, 16'h0999, 4'hA, 1'b0, "minus_999");

        // Start held high: second conversion is accepted in the done cycle,
        // leaving WIDTH busy cycles between the two done pulses.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 12'd5;
        @(negedge clk);
        bin_a  = 12'd999;
        n      = 1;
        first  = 0;
        second = 0;
        while (second == 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (done_a) begin
                if (first == 0) begin
                    first = n;
                    check("b2b first", bcd_a, 16'h0005);
                end else begin
                    second = n;
                    check("b2b second", bcd_a, 16'h0999);
                end
            end
        end
        start_a = 1'b0;
        check("b2b spacing", second - first, WA + 1);

        // Start and bin changes while busy must not disturb or queue anything.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 12'd321;
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = 12'd777;
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        start_a = 1'b0;
        bin_a   = 12'h555;
        dones   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("busy_start dones", dones, 1);
        check("busy_start result", {ovf_a, sgn_a, bcd_a}, {1'b0, 4'hF, 16'h0321});

        // Reset in the middle of a conversion.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 12'd1234;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy_a, 0);
        check("abort done", done_a, 0);
        check("abort out", {ovf_a, sgn_a, bcd_a}, {1'b0, 4'hF, 16'h0000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("abort no_done", dones, 0);
        run(0, 16'd1234, 16'h1234, 4'hF, 1'b0, "after_abort");

        // 16-bit instance: overflow boundary and largest non-overflowing value.
        run(1, 16'h7FFF, 16'hFFFF, 4'hF, 1'b1, "w16_max");
        run(1, 16'd9999, 16'h9999, 4'hF, 1'b0, "w16_9999");
        run(1, 16'd10000, 16'hFFFF, 4'hF, 1'b1, "w16_10000");
        run(1, 16'hD8F0, 16'hFFFF, 4'hA, 1'b1, "w16_neg10000");
        run(1, 16'hD8F1, 16'h9999, 4'hA, 1'b0, "w16_neg9999");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
